// File: rtl/octal_pkg.sv
// Shared types and constants for the octal ASCII streamer path.
package octal_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    TERM
  } state_t;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  // Number of 3-bit octal digits needed to cover a binary value of this width.
  function automatic int octal_digits(input int width);
    return (width + 2) / 3;
  endfunction

endpackage

// File: rtl/octal_lead_digit_enc.sv
// Priority encoder: index of the most significant nonzero octal digit (0 if all zero).
module octal_lead_digit_enc #(
  parameter int NDIG = 6,
  parameter int IDXW = 3
) (
  input  logic [3*NDIG-1:0] digits,
  output logic [IDXW-1:0]   lead_idx
);

  // Later (higher) digits overwrite earlier ones, so the last hit wins.
  always_comb begin
    lead_idx = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (digits[3*i +: 3] != 3'd0) begin
        lead_idx = IDXW'(i);
      end
    end
  end

endmodule

// File: rtl/octal_ascii_streamer.sv
// Streams a binary value as ASCII octal digits, MSD first, with optional trailing LF.
module octal_ascii_streamer
  import octal_pkg::*;
#(
  parameter int DATA_W         = 16,
  parameter bit SUPPRESS_ZEROS = 1'b1,
  parameter bit EMIT_NL        = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_char,
  output logic              out_last,
  output logic              busy
);

  localparam int NDIG = octal_digits(DATA_W);
  localparam int PADW = 3 * NDIG;
  localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IDXW-1:0] TOP_IDX = IDXW'(NDIG - 1);

  state_t          state;
  logic [PADW-1:0] value_q;
  logic [IDXW-1:0] idx_q;
  logic [IDXW-1:0] idx_dec;
  logic [PADW-1:0] in_pad;
  logic [IDXW-1:0] lead_idx;
  logic [IDXW-1:0] start_idx;

  assign in_pad    = PADW'(in_data);
  assign idx_dec   = idx_q - 1'b1;
  assign start_idx = SUPPRESS_ZEROS ? lead_idx : TOP_IDX;

  octal_lead_digit_enc #(
    .NDIG (NDIG),
    .IDXW (IDXW)
  ) u_lead_enc (
    .digits   (in_pad),
    .lead_idx (lead_idx)
  );

  function automatic logic [7:0] digit_char(input logic [PADW-1:0] v,
                                            input logic [IDXW-1:0] i);
    return ASCII_ZERO + {5'd0, v[3*int'(i) +: 3]};
  endfunction

  // Every output is a register loaded one step ahead, so out_char always
  // shows the character for the current index and holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      value_q   <= '0;
      idx_q     <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_char  <= 8'h00;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            state     <= EMIT;
            value_q   <= in_pad;
            idx_q     <= start_idx;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            out_valid <= 1'b1;
            out_char  <= digit_char(in_pad, start_idx);
            out_last  <= !EMIT_NL && (start_idx == '0);
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (idx_q != '0) begin
              idx_q    <= idx_dec;
              out_char <= digit_char(value_q, idx_dec);
              out_last <= !EMIT_NL && (idx_dec == '0);
            end else if (EMIT_NL) begin
              state    <= TERM;
              out_char <= ASCII_LF;
              out_last <= 1'b1;
            end else begin
              state     <= IDLE;
              in_ready  <= 1'b1;
              out_valid <= 1'b0;
              out_char  <= 8'h00;
              out_last  <= 1'b0;
              busy      <= 1'b0;
            end
          end
        end
        TERM: begin
          if (out_ready) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_char  <= 8'h00;
            out_last  <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/octal_ascii_streamer.md
# octal_ascii_streamer

Downstream stage of the decimal-to-octal converter path. Accepts a 16-bit unsigned value over a valid/ready handshake and streams its octal representation as ASCII characters, most significant digit first, one character per accepted output beat. Feeds the UART/console path, replacing base-10-encoded octal words with true per-digit octal output. Octal digits come from 3-bit bit-slices of the binary input; no division is used.

## Interface
- `DATA_W`, 16: input value width; digit count `NDIG = ceil(DATA_W/3)` (6 at default), derived locally.
- `SUPPRESS_ZEROS`, 1: 1 = drop leading zero digits (value 0 still emits one `'0'`); 0 = always emit `NDIG` digits.
- `EMIT_NL`, 1: 1 = append line feed 8'h0A after the last digit.

Ports:
- `clk`  in  1  single clock; all logic rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  block can accept a value; high only in IDLE with `rst_n` high.
- `in_data`  in  DATA_W  unsigned value to print.
- `out_valid`  out  1  `out_char` valid.
- `out_ready`  in  1  sink accepts `out_char`.
- `out_char`  out  8  ASCII character.
- `out_last`  out  1  marks final character of the current value.
- `busy`  out  1  high from accept until the final character handshake.

## Operation
- States: IDLE, EMIT, TERM.
- IDLE: `in_ready`=1. On `in_valid && in_ready`: latch `in_data` zero-padded to `3*NDIG` bits; set digit index to the highest nonzero digit (or 0 if value is 0) when `SUPPRESS_ZEROS`=1, else `NDIG-1`; go to EMIT.
- EMIT: `out_char = 8'h30 + digit[idx]`. On `out_valid && out_ready`: if idx>0, decrement idx; else go to TERM if `EMIT_NL`=1, otherwise IDLE. `out_last`=1 on the idx=0 digit only when `EMIT_NL`=0.
- TERM: `out_char`=8'h0A, `out_last`=1; on handshake go to IDLE.
- Output hold: while `out_valid && !out_ready`, `out_char`/`out_last` are stable and the index does not advance.
- `in_valid` outside IDLE is ignored; no input buffering and no overlap of values.
- Top digit holds `DATA_W mod 3` real bits (bit 15 alone at default); upper pad bits are 0.

## Timing
- Reset (async assert, sync release): state IDLE, `out_valid`=0, `out_char`=8'h00, `out_last`=0, `busy`=0; `in_ready`=0 while `rst_n` low, 1 from the first edge after release.
- Reset mid-stream: the current value is abandoned immediately; no further characters are emitted.
- Latency: accept at edge N; `out_valid`=1 with the first digit from edge N+1.
- Throughput: one character per cycle with `out_ready` held high; value of k digits plus LF occupies k+1 output cycles; `in_ready` returns the cycle after the final handshake (one dead cycle between values).
- `busy` rises at edge N and falls at the edge completing the final handshake.
- All outputs registered or decoded from state/registers only; no combinational path from `in_*` to `out_*` or from `out_ready` to `in_ready`.

## Structure
- Package `octal_pkg`: state enum (IDLE/EMIT/TERM), `ASCII_ZERO`=8'h30, `ASCII_LF`=8'h0A, function `octal_digits(width)` returning `ceil(width/3)`.
- Sub-module `octal_lead_digit_enc`: combinational priority encoder, `NDIG`×3-bit digits in, index of most significant nonzero digit out (0 for all-zero input). Used at load.
- Top: capture register, down-counting digit index, digit mux, FSM.

## Test plan
- 16'd100, `out_ready`=1 -> 8'h31, 8'h34, 8'h34, 8'h0A on consecutive cycles; `out_last` only on 8'h0A; first char one cycle after accept.
- 16'd0 -> 8'h30, 8'h0A. 16'hFFFF -> "177777\n" (8'h31, then 8'h37 ×5, then 8'h0A). 16'd8 -> "10\n".
- `SUPPRESS_ZEROS`=0, `EMIT_NL`=0, 16'd100 -> "000144"; `out_last` on the final 8'h34.
- Random `out_ready` stalls on 16'o123456: `out_char` stable under stall; exact sequence "123456\n"; `in_valid` pulses during streaming are ignored (`in_ready`=0).
- Back-to-back: 16'd7 then 16'd9 with `in_valid` held -> "7\n11\n", second accept one cycle after the first LF handshake.
- `rst_n` pulsed low after the second char of 16'd100 -> outputs drop to reset values immediately; after release, 16'd5 -> "5\n" with no residue.
